// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard, PC-relative read slot and
// optional same-cycle write-to-read forwarding.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int PC_REG   = 15,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              readBusy1,
  output logic              readBusy2,
  input  logic [DATA_W-1:0] pc_plus8,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              issueValid,
  input  logic [ADDR_W-1:0] issueAddr,
  output logic              issueReady,
  output logic [ADDR_W:0]   busyCount
);

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] PC_ADDR    = ADDR_W'(PC_REG);
  localparam logic [ADDR_W:0]   MAX_COUNT  = (ADDR_W+1)'(NUM_REGS - 1);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     count_next;

  logic write_active;
  logic write_in_range;
  logic write_commit;
  logic issue_accept;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < NUM_REGS_W;
  endfunction

  // Bypass only applies while out of reset; flop D paths never see reset.
  function automatic logic bypass_hit(input logic [ADDR_W-1:0] addr);
    return (BYPASS != 0) && write_active && (writeAddr == addr) && (addr != PC_ADDR);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == PC_ADDR)
      return pc_plus8;
    else if (!in_range(addr))
      return '0;
    else if (bypass_hit(addr))
      return writeData;
    else
      return regs[addr];
  endfunction

  function automatic logic read_busy(input logic [ADDR_W-1:0] addr);
    if (!in_range(addr) || bypass_hit(addr))
      return 1'b0;
    else
      return busy[addr];
  endfunction

  assign write_active   = writeEnable & ~reset;
  assign write_in_range = writeEnable & in_range(writeAddr);
  assign write_commit   = write_in_range & (writeAddr != PC_ADDR);

  // A write landing on the issued register frees it in the same cycle.
  assign issue_accept = issueValid & in_range(issueAddr) & (issueAddr != PC_ADDR)
                      & (~busy[issueAddr] | (writeEnable & (writeAddr == issueAddr)));
  assign issueReady   = issue_accept & ~reset;

  assign readData1 = read_port(readAddr1);
  assign readData2 = read_port(readAddr2);
  assign readBusy1 = read_busy(readAddr1);
  assign readBusy2 = read_busy(readAddr2);

  // Issue is applied after the write clear so it wins on a shared address.
  always_comb begin
    busy_next = busy;
    if (write_in_range)
      busy_next[writeAddr] = 1'b0;
    if (issue_accept)
      busy_next[issueAddr] = 1'b1;
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_REGS; i++)
      count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
    if (count_next > MAX_COUNT)
      count_next = MAX_COUNT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy      <= '0;
      busyCount <= '0;
    end else begin
      if (write_commit)
        regs[writeAddr] <= writeData;
      busy      <= busy_next;
      busyCount <= count_next;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard; one instance forwards,
// the other does not, both checked against an array-based model.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int PC = 15;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] readAddr1, readAddr2, writeAddr, issueAddr;
  logic [DW-1:0] pc_plus8, writeData;
  logic          writeEnable, issueValid;

  logic [DW-1:0] rd1, rd2, nb_rd1, nb_rd2;
  logic          busy1, busy2, nb_busy1, nb_busy2;
  logic          ready, nb_ready;
  logic [AW:0]   count, nb_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .PC_REG(PC), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(rd1), .readData2(rd2),
    .readBusy1(busy1), .readBusy2(busy2),
    .pc_plus8(pc_plus8),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .issueValid(issueValid), .issueAddr(issueAddr),
    .issueReady(ready), .busyCount(count)
  );

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .PC_REG(PC), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(nb_rd1), .readData2(nb_rd2),
    .readBusy1(nb_busy1), .readBusy2(nb_busy2),
    .pc_plus8(pc_plus8),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .issueValid(issueValid), .issueAddr(issueAddr),
    .issueReady(nb_ready), .busyCount(nb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic bit write_now(input logic [AW-1:0] a);
    return writeEnable && !reset && (writeAddr == a);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (a == PC) return pc_plus8;
    if (byp && write_now(a)) return writeData;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (byp && write_now(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ready();
    if (reset || !issueValid || issueAddr == PC) return 1'b0;
    return !m_busy[issueAddr] || (writeEnable && writeAddr == issueAddr);
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return (n > NR - 1) ? NR - 1 : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_clock();
    bit acc;
    if (reset) return;
    acc = exp_ready();
    if (writeEnable && writeAddr != PC) m_regs[writeAddr] = writeData;
    if (writeEnable) m_busy[writeAddr] = 1'b0;
    if (acc) m_busy[issueAddr] = 1'b1;
  endtask

  task automatic check_all();
    check("rd1",      rd1,      exp_read(readAddr1, 1'b1));
    check("rd2",      rd2,      exp_read(readAddr2, 1'b1));
    check("busy1",    busy1,    exp_busy(readAddr1, 1'b1));
    check("busy2",    busy2,    exp_busy(readAddr2, 1'b1));
    check("ready",    ready,    exp_ready());
    check("count",    count,    exp_count());
    check("nb_rd1",   nb_rd1,   exp_read(readAddr1, 1'b0));
    check("nb_rd2",   nb_rd2,   exp_read(readAddr2, 1'b0));
    check("nb_busy1", nb_busy1, exp_busy(readAddr1, 1'b0));
    check("nb_busy2", nb_busy2, exp_busy(readAddr2, 1'b0));
    check("nb_ready", nb_ready, exp_ready());
    check("nb_count", nb_count, exp_count());
  endtask

  task automatic apply_stimulus(input bit we, input int wa, input logic [DW-1:0] wd,
                                input bit iv, input int ia, input int ra1, input int ra2,
                                input logic [DW-1:0] pc);
    writeEnable = we;
    writeAddr   = AW'(wa);
    writeData   = wd;
    issueValid  = iv;
    issueAddr   = AW'(ia);
    readAddr1   = AW'(ra1);
    readAddr2   = AW'(ra2);
    pc_plus8    = pc;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_cycle(input bit we, input int wa, input logic [DW-1:0] wd,
                          input bit iv, input int ia, input int ra1, input int ra2,
                          input logic [DW-1:0] pc);
    apply_stimulus(we, wa, wd, iv, ia, ra1, ra2, pc);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check_all();
    check("reset_count", count, 0);
    reset = 1'b0;
    step();

    // Write, then read back next cycle alongside the PC slot.
    do_cycle(1, 3, 32'hDEADBEEF, 0, 0, 0, 15, 32'h108);
    check("pc_read", rd2, 32'h108);
    step();
    do_cycle(0, 0, 0, 0, 0, 3, 15, 32'h108);
    check("r3_read", rd1, 32'hDEADBEEF);
    check("pc_read2", rd2, 32'h108);
    step();

    // Forwarding versus non-forwarding instance.
    do_cycle(1, 5, 32'h55, 0, 0, 5, 0, 32'h108);
    check("bypass_new", rd1, 32'h55);
    check("nobypass_old", nb_rd1, 32'h0);
    step();
    do_cycle(0, 0, 0, 0, 0, 5, 0, 32'h108);
    check("nobypass_after", nb_rd1, 32'h55);
    step();

    // Issue, reissue, then write to release.
    do_cycle(0, 0, 0, 1, 4, 4, 0, 32'h108);
    check("issue_r4", ready, 1);
    step();
    do_cycle(0, 0, 0, 1, 4, 4, 0, 32'h108);
    check("reissue_r4", ready, 0);
    check("count_one", count, 1);
    check("busy_r4", busy1, 1);
    step();
    do_cycle(1, 4, 32'h7, 0, 0, 0, 0, 32'h108);
    step();
    do_cycle(0, 0, 0, 0, 0, 4, 0, 32'h108);
    check("count_zero", count, 0);
    check("busy_r4_clr", busy1, 0);
    check("r4_val", rd1, 32'h7);
    step();

    // Same-cycle write and issue to a busy register: issue wins.
    do_cycle(0, 0, 0, 1, 4, 4, 0, 32'h108);
    step();
    do_cycle(1, 4, 32'h44, 1, 4, 4, 0, 32'h108);
    check("issue_wins_ready", ready, 1);
    check("issue_wins_cnt0", count, 1);
    step();
    do_cycle(0, 0, 0, 0, 0, 4, 0, 32'h108);
    check("issue_wins_busy", busy1, 1);
    check("issue_wins_cnt1", count, 1);
    check("issue_wins_data", rd1, 32'h44);
    step();

    // PC slot is neither writable nor issuable.
    do_cycle(1, 15, 32'h1, 1, 15, 15, 0, 32'h200);
    check("pc_issue", ready, 0);
    check("pc_read3", rd1, 32'h200);
    step();
    do_cycle(0, 0, 0, 0, 0, 15, 0, 32'h200);
    check("pc_not_busy", busy1, 0);
    check("pc_cnt", count, 1);
    check("pc_read4", rd1, 32'h200);
    step();

    for (int n = 0; n < 500; n++) begin
      int wa, ra1, ra2;
      wa  = $urandom_range(0, NR - 1);
      ra1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NR - 1);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NR - 1);
      do_cycle($urandom_range(0, 1) == 1, wa, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, NR - 1),
               ra1, ra2, $urandom);
      step();
    end

    // Clean reset, then pending work interrupted by a mid-cycle reset.
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 32'h108);
    step();
    do_cycle(0, 0, 0, 1, 1, 1, 2, 32'h108);
    step();
    do_cycle(0, 0, 0, 1, 2, 1, 2, 32'h108);
    step();
    do_cycle(1, 1, 32'h9, 0, 0, 1, 2, 32'h108);
    check("r1_fwd", rd1, 32'h9);
    check("pre_rst_cnt", count, 2);
    step();
    apply_stimulus(1, 6, 32'h77, 1, 7, 1, 2, 32'h108);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    check("rst_rd1", rd1, 0);
    check("rst_rd2", rd2, 0);
    check("rst_busy2", busy2, 0);
    check("rst_cnt", count, 0);
    check("rst_ready", ready, 0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 6, 1, 32'h108);
    step();
    do_cycle(0, 0, 0, 0, 0, 6, 1, 32'h108);
    check("dropped_write", rd1, 0);
    check("r1_cleared", rd2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
